// File: rtl/stone_renderer.sv
// Walks the item RAM once per frame-start pulse and paints each visible item as a square.
// Define STONE_RENDER_ERASE_EN to paint invisible items in BG_COLOUR instead of skipping them.
module stone_renderer #(
    parameter int unsigned ITEM_SIZE   = 16,
    parameter int unsigned RAM_LAT     = 2,
    parameter int unsigned SCREEN_W    = 320,
    parameter int unsigned SCREEN_H    = 240,
    parameter logic [2:0]  COL_STONE   = 3'b111,
    parameter logic [2:0]  COL_GOLD    = 3'b110,
    parameter logic [2:0]  COL_DIAMOND = 3'b011,
`ifdef STONE_RENDER_ERASE_EN
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
`endif
    parameter logic [2:0]  COL_OTHER   = 3'b100
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  quantity,
    input  logic [31:0] ram_data,
    output logic        draw_stone_flag,
    output logic [3:0]  draw_index,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        done
);

    localparam int unsigned SH       = $clog2(ITEM_SIZE);
    localparam logic [7:0]  LAST_PIX = 8'(ITEM_SIZE * ITEM_SIZE - 1);
    localparam logic [7:0]  OFS_MASK = 8'(ITEM_SIZE - 1);
    localparam logic [3:0]  LAT_INIT = 4'(RAM_LAT - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, PLOT, NEXT, DONE} state_t;

    state_t      state, state_n;
    logic [8:0]  px, px_n;
    logic [7:0]  py, py_n;
    logic [3:0]  wcnt, wcnt_n;
    logic [7:0]  pix, pix_n;
    logic        flag_n, done_n, plot_n;
    logic [3:0]  idx_n;
    logic [8:0]  x_n;
    logic [7:0]  y_n;
    logic [2:0]  col_n, type_col;

    logic [8:0]  bx;
    logic [7:0]  by, p, dx, dy;
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic        in_bounds, go_plot;

    logic unused_ram_bits;
    assign unused_ram_bits = ^{ram_data[31:28], ram_data[18:15], ram_data[6:4], ram_data[0]};

    always_comb begin
        unique case (ram_data[3:2])
            2'b00:   type_col = COL_STONE;
            2'b01:   type_col = COL_GOLD;
            2'b10:   type_col = COL_DIAMOND;
            default: type_col = COL_OTHER;
        endcase
    end

    // LATCH emits pixel 0 straight from ram_data so the first plot lands in the first PLOT cycle;
    // PLOT then emits pixel pix+1, which keeps the item at exactly ITEM_SIZE^2 plot cycles.
    always_comb begin
        bx        = (state == LATCH) ? ram_data[27:19] : px;
        by        = (state == LATCH) ? ram_data[14:7]  : py;
        p         = (state == LATCH) ? 8'd0 : pix + 8'd1;
        dx        = p & OFS_MASK;
        dy        = p >> SH;
        sx        = {1'b0, bx} + {2'b00, dx};
        sy        = {1'b0, by} + {1'b0, dy};
        in_bounds = (sx < 10'(SCREEN_W)) && (sy < 9'(SCREEN_H));
`ifdef STONE_RENDER_ERASE_EN
        go_plot   = 1'b1;
`else
        go_plot   = ram_data[1];
`endif
    end

    always_comb begin
        state_n = state;
        px_n    = px;
        py_n    = py;
        wcnt_n  = wcnt;
        pix_n   = pix;
        flag_n  = draw_stone_flag;
        idx_n   = draw_index;
        x_n     = vga_x;
        y_n     = vga_y;
        col_n   = colour;
        plot_n  = plot;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (quantity == 4'd0) begin
                        state_n = DONE;
                    end else begin
                        state_n = ADDR;
                        idx_n   = '0;
                        flag_n  = 1'b1;
                    end
                end
            end
            ADDR: begin
                state_n = WAIT;
                wcnt_n  = LAT_INIT;
            end
            WAIT: begin
                if (wcnt == 4'd0) state_n = LATCH;
                else              wcnt_n  = wcnt - 4'd1;
            end
            LATCH: begin
                px_n  = ram_data[27:19];
                py_n  = ram_data[14:7];
                pix_n = '0;
                if (go_plot) begin
                    state_n = PLOT;
                    x_n     = sx[8:0];
                    y_n     = sy[7:0];
                    plot_n  = in_bounds;
`ifdef STONE_RENDER_ERASE_EN
                    col_n   = ram_data[1] ? type_col : BG_COLOUR;
`else
                    col_n   = type_col;
`endif
                end else begin
                    state_n = NEXT;
                end
            end
            PLOT: begin
                if (pix == LAST_PIX) begin
                    state_n = NEXT;
                    plot_n  = 1'b0;
                end else begin
                    pix_n  = pix + 8'd1;
                    x_n    = sx[8:0];
                    y_n    = sy[7:0];
                    plot_n = in_bounds;
                end
            end
            NEXT: begin
                if (({1'b0, draw_index} + 5'd1 >= {1'b0, quantity}) || (draw_index == 4'hF)) begin
                    state_n = DONE;
                end else begin
                    state_n = ADDR;
                    idx_n   = draw_index + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
                flag_n  = 1'b0;
                done_n  = 1'b1;
                idx_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state           <= IDLE;
            px              <= '0;
            py              <= '0;
            wcnt            <= '0;
            pix             <= '0;
            draw_stone_flag <= 1'b0;
            draw_index      <= '0;
            vga_x           <= '0;
            vga_y           <= '0;
            colour          <= '0;
            plot            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_n;
            px              <= px_n;
            py              <= py_n;
            wcnt            <= wcnt_n;
            pix             <= pix_n;
            draw_stone_flag <= flag_n;
            draw_index      <= idx_n;
            vga_x           <= x_n;
            vga_y           <= y_n;
            colour          <= col_n;
            plot            <= plot_n;
            done            <= done_n;
        end
    end

endmodule

// File: tb/tb_stone_renderer.sv
// Directed bench for stone_renderer: a 2-cycle-latency RAM model, a walk vector table and corner sequences.
module tb_stone_renderer;

    logic        clock = 1'b0;
    logic        resetn, start;
    logic [3:0]  quantity;
    logic [31:0] ram_data = '0;
    logic        draw_stone_flag, plot, done;
    logic [3:0]  draw_index;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  colour;

    int tests  = 0;
    int failed = 0;

    logic [31:0] mem [16];
    logic [31:0] d1 = '0;

    stone_renderer dut (
        .clock(clock), .resetn(resetn), .start(start), .quantity(quantity),
        .ram_data(ram_data), .draw_stone_flag(draw_stone_flag), .draw_index(draw_index),
        .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        d1       <= mem[draw_index];
        ram_data <= d1;
    end

    typedef struct {
        int q;
        logic [31:0] r0, r1, r2;
        int plots, flag_cyc, done_cyc, idx_mask, plots1;
        int fx, fy, fc, lx, ly, lc;
    } vec_t;

    vec_t vecs[5];

    // walk measurements
    int nplot, nplot1, nflag, mask, done_cyc, ndone_extra, cyc;
    int fx, fy, fc, lx, ly, lc;
    bit got_done;

    function automatic logic [31:0] rec(input int x, input int y, input int t, input int v, input int m);
        return {13'(x), 12'(y), 3'b000, 2'(t), 1'(v), 1'(m)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic sample();
        if (plot) begin
            if (nplot == 0) begin fx = vga_x; fy = vga_y; fc = colour; end
            lx = vga_x; ly = vga_y; lc = colour;
            nplot++;
            if (draw_index == 4'd1) nplot1++;
        end
        if (draw_stone_flag) begin
            nflag++;
            mask |= (1 << draw_index);
        end
        if (done && !got_done) begin
            got_done = 1'b1;
            done_cyc = cyc;
        end else if (done) begin
            ndone_extra++;
        end
    endtask

    // start pulse is sampled on the edge after this call; cyc counts edges since then
    task automatic run_walk(input int q, input int budget);
        nplot = 0; nplot1 = 0; nflag = 0; mask = 0; done_cyc = 0; ndone_extra = 0;
        fx = -1; fy = -1; fc = -1; lx = -1; ly = -1; lc = -1;
        got_done = 1'b0;
        quantity = 4'(q);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        sample();
        while (!got_done && cyc < budget) begin
            @(negedge clock);
            cyc++;
            sample();
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            cyc++;
            sample();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        vecs[0] = '{q: 1, r0: rec(100, 50, 1, 1, 0), r1: '0, r2: '0,
                    plots: 256, flag_cyc: 262, done_cyc: 263, idx_mask: 1, plots1: 0,
                    fx: 100, fy: 50, fc: 6, lx: 115, ly: 65, lc: 6};
`ifdef STONE_RENDER_ERASE_EN
        vecs[1] = '{q: 3, r0: rec(10, 20, 0, 1, 0), r1: rec(200, 100, 3, 0, 0), r2: rec(40, 60, 2, 1, 0),
                    plots: 768, flag_cyc: 784, done_cyc: 785, idx_mask: 7, plots1: 256,
                    fx: 10, fy: 20, fc: 7, lx: 55, ly: 75, lc: 3};
        vecs[4] = '{q: 2, r0: rec(0, 0, 2, 0, 0), r1: rec(16, 16, 1, 0, 1), r2: '0,
                    plots: 512, flag_cyc: 523, done_cyc: 524, idx_mask: 3, plots1: 256,
                    fx: 0, fy: 0, fc: 0, lx: 31, ly: 31, lc: 0};
`else
        vecs[1] = '{q: 3, r0: rec(10, 20, 0, 1, 0), r1: rec(200, 100, 3, 0, 0), r2: rec(40, 60, 2, 1, 0),
                    plots: 512, flag_cyc: 528, done_cyc: 529, idx_mask: 7, plots1: 0,
                    fx: 10, fy: 20, fc: 7, lx: 55, ly: 75, lc: 3};
        vecs[4] = '{q: 2, r0: rec(0, 0, 2, 0, 0), r1: rec(16, 16, 1, 0, 1), r2: '0,
                    plots: 0, flag_cyc: 11, done_cyc: 12, idx_mask: 3, plots1: 0,
                    fx: 0, fy: 0, fc: 0, lx: 0, ly: 0, lc: 0};
`endif
        // X field has bit 12 set and moving=1: both must be ignored
        vecs[2] = '{q: 1, r0: rec(4096 + 312, 236, 0, 1, 1), r1: '0, r2: '0,
                    plots: 32, flag_cyc: 262, done_cyc: 263, idx_mask: 1, plots1: 0,
                    fx: 312, fy: 236, fc: 7, lx: 319, ly: 239, lc: 7};
        vecs[3] = '{q: 0, r0: rec(5, 5, 0, 1, 0), r1: '0, r2: '0,
                    plots: 0, flag_cyc: 0, done_cyc: 2, idx_mask: 0, plots1: 0,
                    fx: 0, fy: 0, fc: 0, lx: 0, ly: 0, lc: 0};

        resetn = 1'b0; start = 1'b0; quantity = '0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        // idle with no start: every output stays at its reset value
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("idle_outputs", int'({draw_stone_flag, draw_index, vga_x, vga_y, colour, plot, done}), 0);
        end

        for (int v = 0; v < 5; v++) begin
            mem[0] = vecs[v].r0; mem[1] = vecs[v].r1; mem[2] = vecs[v].r2;
            run_walk(vecs[v].q, 3000);
            check($sformatf("v%0d_done_seen", v), int'(got_done), 1);
            check($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].done_cyc);
            check($sformatf("v%0d_extra_done", v), ndone_extra, 0);
            check($sformatf("v%0d_plots", v), nplot, vecs[v].plots);
            check($sformatf("v%0d_flag_cycles", v), nflag, vecs[v].flag_cyc);
            check($sformatf("v%0d_index_mask", v), mask, vecs[v].idx_mask);
            check($sformatf("v%0d_plots_index1", v), nplot1, vecs[v].plots1);
            check($sformatf("v%0d_flag_after", v), int'(draw_stone_flag), 0);
            if (vecs[v].plots > 0) begin
                check($sformatf("v%0d_first_pixel", v), fx * 1000 + fy, vecs[v].fx * 1000 + vecs[v].fy);
                check($sformatf("v%0d_first_colour", v), fc, vecs[v].fc);
                check($sformatf("v%0d_last_pixel", v), lx * 1000 + ly, vecs[v].lx * 1000 + vecs[v].ly);
                check($sformatf("v%0d_last_colour", v), lc, vecs[v].lc);
            end
        end

        // start mid-walk and on the DONE->IDLE edge must both be ignored
        mem[0] = rec(100, 50, 1, 1, 0);
        nflag = 0; ndone_extra = 0;
        quantity = 4'd1;
        start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clock);
            start = (c == 100 || c == 262);
            if (draw_stone_flag) nflag++;
            if (done) ndone_extra++;
        end
        start = 1'b0;
        check("ignored_start_done_count", ndone_extra, 1);
        check("ignored_start_flag_cycles", nflag, 262);

        // reset during PLOT of item 2 aborts the walk
        mem[0] = rec(10, 20, 0, 1, 0); mem[1] = rec(200, 100, 3, 0, 0); mem[2] = rec(40, 60, 2, 1, 0);
        quantity = 4'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        got_done = 1'b0;
        for (int c = 0; c < 1000 && !got_done; c++) begin
            @(negedge clock);
            if (draw_index == 4'd2 && plot) got_done = 1'b1;
        end
        check("reached_item2_plot", int'(got_done), 1);
        resetn = 1'b0;
        @(negedge clock);
        check("abort_plot", int'(plot), 0);
        check("abort_flag", int'(draw_stone_flag), 0);
        check("abort_done", int'(done), 0);
        check("abort_index", int'(draw_index), 0);
        resetn = 1'b1;
        @(negedge clock);
        check("abort_no_late_done", int'(done), 0);

        quantity = 4'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("restart_flag", int'(draw_stone_flag), 1);
        check("restart_index", int'(draw_index), 0);
        got_done = 1'b0; nplot = 0;
        for (int c = 0; c < 600 && !got_done; c++) begin
            @(negedge clock);
            if (plot) nplot++;
            if (done) got_done = 1'b1;
        end
        check("restart_done_seen", int'(got_done), 1);
        check("restart_plots", nplot, 256);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
